// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: architectural PC register and instruction-fetch sequencer.
// Issues one outstanding fetch at a time and presents the fetched word to
// decode with a valid/ready handshake. A flush redirects fetch to npc_in. A
// flush that lands while a request is still outstanding marks that response
// to be thrown away. A misaligned next PC parks the block in HALT with a
// sticky error.
module pc_fetch_stage #(
  parameter int unsigned        SIZE     = 32,
  parameter logic [SIZE-1:0]    RESET_PC = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] npc_in,
  input  logic            flush,
  output logic [SIZE-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [SIZE-1:0] imem_rdata,
  output logic [SIZE-1:0] ins_out,
  output logic [SIZE-1:0] pc_out,
  output logic [SIZE-1:0] pc4_out,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic            misalign_err,
  output logic [SIZE-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [SIZE-1:0] PC_STEP  = {{(SIZE-3){1'b0}}, 3'b100};
  localparam logic [SIZE-1:0] CNT_STEP = {{(SIZE-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;           // architectural PC
  logic [SIZE-1:0] addr_q, addr_d;       // address of the request on the bus
  logic            req_q, req_d;
  logic            drop_q, drop_d;       // outstanding response must be discarded
  logic [SIZE-1:0] ins_q, ins_d;
  logic [SIZE-1:0] pc_out_q, pc_out_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [SIZE-1:0] cnt_q, cnt_d;

  logic            ack_s;
  logic            aligned_s;

  // A response only counts while a request is actually being driven.
  assign ack_s     = req_q & imem_ack;
  assign aligned_s = (npc_in[1:0] == 2'b00);

  // Next-state and datapath decisions; every register holds unless changed.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q;
    drop_d   = drop_q;
    ins_d    = ins_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        if (flush) begin
          pc_d = npc_in;
          if (ack_s) begin
            drop_d = 1'b0;
            addr_d = npc_in;
          end else if (req_q) begin
            // request still in flight: keep its address, discard its data later
            drop_d = 1'b1;
          end else begin
            addr_d = npc_in;
          end
        end else if (ack_s) begin
          if (drop_q) begin
            drop_d = 1'b0;
            addr_d = pc_q;
          end else begin
            ins_d    = imem_rdata;
            pc_out_d = addr_q;
            valid_d  = 1'b1;
            req_d    = 1'b0;
            state_d  = S_HOLD;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      S_HOLD: begin
        req_d = 1'b0;
        if (flush) begin
          pc_d    = npc_in;
          addr_d  = npc_in;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (ins_ready) begin
          cnt_d   = cnt_q + CNT_STEP;
          valid_d = 1'b0;
          pc_d    = npc_in;
          addr_d  = npc_in;
          if (aligned_s) begin
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        if (flush) begin
          pc_d   = npc_in;
          addr_d = npc_in;
          if (aligned_s) begin
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the reset PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      ins_q    <= {SIZE{1'b0}};
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= {SIZE{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      drop_q   <= drop_d;
      ins_q    <= ins_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr    = addr_q;
  assign imem_req     = req_q;
  assign ins_out      = ins_q;
  assign pc_out       = pc_out_q;
  assign pc4_out      = pc_out_q + PC_STEP;
  assign ins_valid    = valid_q;
  assign misalign_err = err_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed stimulus, a transaction-level model
// compared every cycle, and literal expectations at the key points.
module tb_pc_fetch_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc_in;
  logic        flush;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        ins_valid;
  logic        ins_ready;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic        use_seq;
  logic [31:0] npc_man;

  int n_chk = 0;
  int n_err = 0;

  assign npc_in = use_seq ? pc4_out : npc_man;

  pc_fetch_stage #(.SIZE(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .flush(flush),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ins_out(ins_out), .pc_out(pc_out),
    .pc4_out(pc4_out), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one request on the bus, one word held for decode.
  logic [31:0] m_pc      = RPC;
  logic [31:0] m_addr    = RPC;
  logic        m_req     = 1'b0;
  logic        m_discard = 1'b0;
  logic        m_valid   = 1'b0;
  logic        m_halt    = 1'b0;
  logic [31:0] m_ins     = 32'h0;
  logic [31:0] m_pcout   = RPC;
  logic [31:0] m_cnt     = 32'h0;
  logic        m_err     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic ack;
    if (!rst_n) begin
      m_pc = RPC; m_addr = RPC; m_req = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
      m_halt = 1'b0; m_ins = 32'h0; m_pcout = RPC; m_cnt = 32'h0; m_err = 1'b0;
    end else begin
      ack = m_req && imem_ack;
      if (flush) begin
        m_pc = npc_in;
        if (m_halt) begin
          m_addr = npc_in;
          if (npc_in % 4 == 0) begin m_halt = 1'b0; m_req = 1'b1; end
          else m_err = 1'b1;
        end else if (m_valid) begin
          m_valid = 1'b0; m_addr = npc_in; m_req = 1'b1;
        end else begin
          if (m_req && !ack) m_discard = 1'b1;
          else begin m_discard = 1'b0; m_addr = npc_in; end
          m_req = 1'b1;
        end
      end else if (m_halt) begin
        m_req = 1'b0;
      end else if (m_valid) begin
        if (ins_ready) begin
          m_cnt = m_cnt + 32'd1; m_valid = 1'b0; m_pc = npc_in; m_addr = npc_in;
          if (npc_in % 4 != 0) begin m_err = 1'b1; m_halt = 1'b1; end
          else m_req = 1'b1;
        end
      end else if (ack) begin
        if (m_discard) begin m_discard = 1'b0; m_addr = m_pc; end
        else begin m_valid = 1'b1; m_ins = imem_rdata; m_pcout = m_addr; m_req = 1'b0; end
      end else begin
        m_req = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("addr", imem_addr, m_addr);
    chk("valid", 32'(ins_valid), 32'(m_valid));
    chk("ins_out", ins_out, m_ins);
    chk("pc_out", pc_out, m_pcout);
    chk("pc4_out", pc4_out, m_pcout + 32'd4);
    chk("misalign", 32'(misalign_err), 32'(m_err));
    chk("count", fetch_count, m_cnt);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Hold ack low for lat cycles, then ack once with data; ends in HOLD.
  task automatic fetch_one(input int lat, input logic [31:0] data);
    imem_ack = 1'b0;
    repeat (lat) tick();
    imem_ack = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    ins_ready = 1'b1; use_seq = 1'b1; npc_man = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // reset state
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0040_0000);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc4", pc4_out, 32'h0040_0004);
    chk("rst_ins", ins_out, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0040_0000);

    // immediate ack
    fetch_one(0, 32'h8C08_0004);
    chk("t1_ins", ins_out, 32'h8C08_0004);
    chk("t1_pc", pc_out, 32'h0040_0000);
    tick();
    chk("t1_next_addr", imem_addr, 32'h0040_0004);
    chk("t1_count", fetch_count, 32'd1);

    // ack after 3 cycles
    fetch_one(3, 32'h2010_0008);
    chk("t2_ins", ins_out, 32'h2010_0008);
    chk("t2_pc", pc_out, 32'h0040_0004);
    tick();
    chk("t2_next_addr", imem_addr, 32'h0040_0008);
    chk("t2_count", fetch_count, 32'd2);

    // decode stalls for 5 cycles
    ins_ready = 1'b0;
    fetch_one(1, 32'hAC09_000C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(ins_valid), 32'd1);
      chk("t3_hold_ins", ins_out, 32'hAC09_000C);
      chk("t3_hold_pc", pc_out, 32'h0040_0008);
      chk("t3_hold_req", 32'(imem_req), 32'd0);
    end
    ins_ready = 1'b1;
    tick();
    chk("t3_count", fetch_count, 32'd3);
    chk("t3_next_addr", imem_addr, 32'h0040_000C);

    // flush while a request is outstanding; its response is discarded
    use_seq = 1'b0; npc_man = 32'h0040_0100; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_old_addr", imem_addr, 32'h0040_000C);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("t4_no_valid", 32'(ins_valid), 32'd0);
    chk("t4_new_addr", imem_addr, 32'h0040_0100);
    npc_man = 32'h0040_0102;
    fetch_one(0, 32'h1234_5678);
    chk("t4_ins", ins_out, 32'h1234_5678);
    chk("t4_pc", pc_out, 32'h0040_0100);

    // misaligned next PC at the handshake
    tick();
    chk("t5_err", 32'(misalign_err), 32'd1);
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_count", fetch_count, 32'd4);
    repeat (3) begin
      tick();
      chk("t5_halt_req", 32'(imem_req), 32'd0);
    end
    npc_man = 32'h0040_0200; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_resume_req", 32'(imem_req), 32'd1);
    chk("t5_resume_addr", imem_addr, 32'h0040_0200);
    chk("t5_err_sticky", 32'(misalign_err), 32'd1);
    use_seq = 1'b1; ins_ready = 1'b0;
    fetch_one(0, 32'h0BAD_F00D);
    chk("t5_ins", ins_out, 32'h0BAD_F00D);
    chk("t5_pc", pc_out, 32'h0040_0200);

    // asynchronous reset mid-HOLD
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(ins_valid), 32'd0);
    chk("t6_ins", ins_out, 32'd0);
    chk("t6_pc", pc_out, 32'h0040_0000);
    chk("t6_pc4", pc4_out, 32'h0040_0004);
    chk("t6_err", 32'(misalign_err), 32'd0);
    chk("t6_count", fetch_count, 32'd0);
    chk("t6_req", 32'(imem_req), 32'd0);
    tick();
    rst_n = 1'b1; ins_ready = 1'b1;
    use_seq = 1'b0; npc_man = 32'hFFFF_FFFC; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t7_addr", imem_addr, 32'hFFFF_FFFC);
    use_seq = 1'b1;
    fetch_one(0, 32'h0000_0013);
    chk("t7_pc", pc_out, 32'hFFFF_FFFC);
    chk("t7_pc4_wrap", pc4_out, 32'h0000_0000);
    tick();
    chk("t7_wrap_addr", imem_addr, 32'h0000_0000);
    chk("t7_count", fetch_count, 32'd1);

    // flush and ack in the same cycle
    use_seq = 1'b0; npc_man = 32'h0000_0040; flush = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
    tick();
    flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("t8_valid", 32'(ins_valid), 32'd0);
    chk("t8_addr", imem_addr, 32'h0000_0040);
    fetch_one(0, 32'h5555_AAAA);
    chk("t8_ins", ins_out, 32'h5555_AAAA);
    chk("t8_pc", pc_out, 32'h0000_0040);

    // flush concurrent with the handshake is not counted
    npc_man = 32'h0000_0080; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t9_count", fetch_count, 32'd1);
    chk("t9_addr", imem_addr, 32'h0000_0080);
    chk("t9_valid", 32'(ins_valid), 32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
